jt7759_cmdq: RTL

- Command queue and scheduler that feeds sound-index writes into the jt7759 control unit when it runs in slave mode (mdn=0).
- The CPU posts sample indices at any rate. The block buffers them in a small FIFO.
- It issues one index to the control unit only when the chip reports idle (busyn=1), and supervises playback start.
- It also provides a stop/flush path that resets the sound chip.

---
 rtl/jt7759_cmdq_if.sv | 29 ++
 rtl/jt7759_cmdq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_cmdq_if.sv
// CPU-side command bus and sound-chip control bus of the jt7759 command queue.
interface jt7759_cmdq_if #(
    parameter int AW = 2
);
    logic          cpu_wr;
    logic [7:0]    cpu_din;
    logic          cpu_stop;
    logic          q_empty;
    logic          q_full;
    logic [AW:0]   q_level;
    logic          ovf;
    logic          tmo;
    logic          snd_cs;
    logic [7:0]    snd_din;
    logic          snd_busyn;
    logic          snd_rst;

    // CPU and sound chip side: drives commands and busy_n, observes status
    modport master (
        output cpu_wr, cpu_din, cpu_stop, snd_busyn,
        input  q_empty, q_full, q_level, ovf, tmo, snd_cs, snd_din, snd_rst
    );

    // Queue/scheduler side
    modport slave (
        input  cpu_wr, cpu_din, cpu_stop, snd_busyn,
        output q_empty, q_full, q_level, ovf, tmo, snd_cs, snd_din, snd_rst
    );
endinterface

// File: rtl/jt7759_cmdq.sv
// Command queue and scheduler feeding sound indices into the jt7759 control
// unit in slave mode. Buffers CPU writes, issues one index whenever the chip
// is idle, supervises playback start and offers a stop/flush path.
module jt7759_cmdq #(
    parameter int AW     = 2,
    parameter int TMO    = 16,
    parameter int RSTLEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen4,
    jt7759_cmdq_if.slave   bus
);
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (TMO > RSTLEN) ? TMO : RSTLEN;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RSTLEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ACKW    = 3'd4,
        ST_PLAY    = 3'd5,
        ST_GAP     = 3'd6,
        ST_ABORT   = 3'd7
    } state_t;

    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic          cs_r, cs_nx;
    logic [7:0]    din_r, din_nx;
    logic          snd_rst_r, snd_rst_nx;
    logic          tmo_r, tmo_nx;
    logic          ovf_r, ovf_nx;
    logic [AW:0]   wr_ptr_r, wr_nx;
    logic [AW:0]   rd_ptr_r, rd_nx;
    logic [AW:0]   level_r, level_nx;
    logic          empty_r, empty_nx;
    logic          full_r, full_nx;
    logic          pop_s;
    logic          push_s;
    logic [7:0]    head_s;
    logic [7:0]    mem_r [DEPTH];

    assign head_s = mem_r[rd_ptr_r[AW-1:0]];

    // Scheduler next state: stop wins on any clk, everything else steps on cen4
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        cs_nx      = cs_r;
        din_nx     = din_r;
        snd_rst_nx = snd_rst_r;
        tmo_nx     = 1'b0;
        pop_s      = 1'b0;
        if (bus.cpu_stop) begin
            state_nx   = ST_ABORT;
            cnt_nx     = CNT_ZERO;
            cs_nx      = 1'b0;
            snd_rst_nx = 1'b1;
        end else if (cen4) begin
            case (state_r)
                ST_IDLE: begin
                    cs_nx = 1'b0;
                    if (!empty_r && bus.snd_busyn) begin
                        din_nx   = head_s;
                        state_nx = ST_SETUP;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // the head leaves the queue as the strobe rises
                    cs_nx    = 1'b1;
                    pop_s    = 1'b1;
                    state_nx = ST_STROBE;
                end
                ST_STROBE: begin
                    cs_nx    = 1'b0;
                    state_nx = ST_RELEASE;
                end
                ST_RELEASE: begin
                    cs_nx    = 1'b0;
                    cnt_nx   = CNT_ZERO;
                    state_nx = ST_ACKW;
                end
                ST_ACKW: begin
                    if (!bus.snd_busyn) begin
                        state_nx = ST_PLAY;
                    end else if (cnt_r == TMO_LAST) begin
                        // command lost; it is not re-queued
                        tmo_nx   = 1'b1;
                        cnt_nx   = CNT_ZERO;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx   = cnt_r + CNT_ONE;
                    end
                end
                ST_PLAY: begin
                    if (bus.snd_busyn) begin
                        state_nx = ST_GAP;
                    end else begin
                        state_nx = ST_PLAY;
                    end
                end
                ST_GAP: begin
                    // guarantees a fresh rising edge on the next strobe
                    cs_nx    = 1'b0;
                    state_nx = ST_IDLE;
                end
                ST_ABORT: begin
                    cs_nx = 1'b0;
                    if (cnt_r == RST_LAST) begin
                        snd_rst_nx = 1'b0;
                        cnt_nx     = CNT_ZERO;
                        state_nx   = ST_IDLE;
                    end else begin
                        cnt_nx     = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nx   = ST_IDLE;
                    cs_nx      = 1'b0;
                    snd_rst_nx = 1'b0;
                    cnt_nx     = CNT_ZERO;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // FIFO pointer update: flush on stop, push/pop otherwise (both allowed when full)
    always_comb begin
        wr_nx  = wr_ptr_r;
        rd_nx  = rd_ptr_r;
        push_s = 1'b0;
        ovf_nx = 1'b0;
        if (bus.cpu_stop) begin
            rd_nx = wr_ptr_r;
        end else begin
            if (pop_s) begin
                rd_nx = rd_ptr_r + PTR_ONE;
            end else begin
                rd_nx = rd_ptr_r;
            end
            if (bus.cpu_wr) begin
                if (!full_r || pop_s) begin
                    push_s = 1'b1;
                    wr_nx  = wr_ptr_r + PTR_ONE;
                end else begin
                    ovf_nx = 1'b1;
                end
            end else begin
                wr_nx = wr_ptr_r;
            end
        end
        level_nx = wr_nx - rd_nx;
        empty_nx = (wr_nx == rd_nx);
        full_nx  = (level_nx == LVL_FULL);
    end

    // State, counters, pointers and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            cs_r      <= 1'b0;
            din_r     <= 8'h00;
            snd_rst_r <= 1'b0;
            tmo_r     <= 1'b0;
            ovf_r     <= 1'b0;
            wr_ptr_r  <= {(AW + 1){1'b0}};
            rd_ptr_r  <= {(AW + 1){1'b0}};
            level_r   <= {(AW + 1){1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            cs_r      <= cs_nx;
            din_r     <= din_nx;
            snd_rst_r <= snd_rst_nx;
            tmo_r     <= tmo_nx;
            ovf_r     <= ovf_nx;
            wr_ptr_r  <= wr_nx;
            rd_ptr_r  <= rd_nx;
            level_r   <= level_nx;
            empty_r   <= empty_nx;
            full_r    <= full_nx;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.cpu_din;
        end
    end

    assign bus.q_empty = empty_r;
    assign bus.q_full  = full_r;
    assign bus.q_level = level_r;
    assign bus.ovf     = ovf_r;
    assign bus.tmo     = tmo_r;
    assign bus.snd_cs  = cs_r;
    assign bus.snd_din = din_r;
    assign bus.snd_rst = snd_rst_r;
endmodule
